// File: rtl/alu_issue_stage_pkg.sv
// Shared ALU defines and small helpers for the ID/EX issue stage.
package alu_issue_stage_pkg;

  // Register index width (RISC-V style 32-entry file).
  localparam int REG_W = 5;

  // ALU operation codes shared with the ALU and the decoder.
  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_SLL  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_SLT  = 4'd8;
  localparam logic [3:0] ALU_SLTU = 4'd9;

  // True when a source register is actually read and names the given destination.
  function automatic logic src_hits(input logic use_src, input logic [REG_W-1:0] rs,
                                    input logic [REG_W-1:0] rd);
    return use_src && (rs == rd);
  endfunction

endpackage

// File: rtl/alu_issue_stage_fwd.sv
// Operand forwarding mux: MEM result beats WB result beats the registered read; x0 never forwards.
module fwd_select
  import alu_issue_stage_pkg::*;
#(
  parameter int N = 32
) (
  input  logic [REG_W-1:0] ex_rs,
  input  logic [N-1:0]     reg_data,
  input  logic [REG_W-1:0] mem_rd,
  input  logic             mem_reg_write,
  input  logic [N-1:0]     mem_result,
  input  logic [REG_W-1:0] wb_rd,
  input  logic             wb_reg_write,
  input  logic [N-1:0]     wb_result,
  output logic [N-1:0]     fwd_data
);

  // Pick the youngest in-flight producer of ex_rs, falling back to the register file value.
  always_comb begin
    fwd_data = reg_data;
    if (mem_reg_write && (mem_rd != '0) && (mem_rd == ex_rs)) begin
      fwd_data = mem_result;
    end else if (wb_reg_write && (wb_rd != '0) && (wb_rd == ex_rs)) begin
      fwd_data = wb_result;
    end
  end

endmodule

// File: rtl/alu_issue_stage.sv
// ID/EX pipeline register with load-use hazard stall, flush squash and operand forwarding.
module alu_issue_stage
  import alu_issue_stage_pkg::*;
#(
  parameter int N     = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic [N-1:0]     id_pc,
  input  logic [N-1:0]     id_rs1_data,
  input  logic [N-1:0]     id_rs2_data,
  input  logic [N-1:0]     id_imm,
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic [REG_W-1:0] id_rd,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic             id_a_pc,
  input  logic             id_b_imm,
  input  logic [3:0]       id_alu_sel,
  input  logic             id_reg_write,
  input  logic             id_mem_read,
  input  logic             id_mem_write,
  input  logic             flush,
  input  logic [REG_W-1:0] mem_rd,
  input  logic [REG_W-1:0] wb_rd,
  input  logic             mem_reg_write,
  input  logic             wb_reg_write,
  input  logic [N-1:0]     mem_result,
  input  logic [N-1:0]     wb_result,
  output logic             stall_o,
  output logic [N-1:0]     alu_a,
  output logic [N-1:0]     alu_b,
  output logic [3:0]       alu_sel_o,
  output logic             ex_valid,
  output logic             ex_reg_write,
  output logic             ex_mem_read,
  output logic             ex_mem_write,
  output logic [REG_W-1:0] ex_rd,
  output logic [N-1:0]     ex_store_data,
  output logic [CNT_W-1:0] bubble_cnt
);

  logic             ex_valid_q, ex_valid_d;
  logic [N-1:0]     ex_pc_q, ex_pc_d;
  logic [N-1:0]     ex_rs1_data_q, ex_rs1_data_d;
  logic [N-1:0]     ex_rs2_data_q, ex_rs2_data_d;
  logic [N-1:0]     ex_imm_q, ex_imm_d;
  logic [REG_W-1:0] ex_rs1_q, ex_rs1_d;
  logic [REG_W-1:0] ex_rs2_q, ex_rs2_d;
  logic [REG_W-1:0] ex_rd_q, ex_rd_d;
  logic             ex_a_pc_q, ex_a_pc_d;
  logic             ex_b_imm_q, ex_b_imm_d;
  logic [3:0]       ex_alu_sel_q, ex_alu_sel_d;
  logic             ex_reg_write_q, ex_reg_write_d;
  logic             ex_mem_read_q, ex_mem_read_d;
  logic             ex_mem_write_q, ex_mem_write_d;
  logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;

  logic             load_use;
  logic [N-1:0]     fwd_rs1;
  logic [N-1:0]     fwd_rs2;

  // A load in EX whose destination feeds the instruction in ID cannot forward in time.
  assign load_use = ex_valid_q && ex_mem_read_q && (ex_rd_q != '0) && id_valid &&
                    (src_hits(id_use_rs1, id_rs1, ex_rd_q) || src_hits(id_use_rs2, id_rs2, ex_rd_q));

  // A redirect kills the ID instruction anyway, so holding it would be pointless.
  assign stall_o = load_use && !flush;

  // Next ID/EX contents: squash to an empty ADD slot on flush or bubble, else capture decode.
  always_comb begin
    ex_valid_d     = id_valid;
    ex_pc_d        = id_pc;
    ex_rs1_data_d  = id_rs1_data;
    ex_rs2_data_d  = id_rs2_data;
    ex_imm_d       = id_imm;
    ex_rs1_d       = id_rs1;
    ex_rs2_d       = id_rs2;
    ex_rd_d        = id_rd;
    ex_a_pc_d      = id_a_pc;
    ex_b_imm_d     = id_b_imm;
    ex_alu_sel_d   = id_alu_sel;
    ex_reg_write_d = id_reg_write;
    ex_mem_read_d  = id_mem_read;
    ex_mem_write_d = id_mem_write;
    if (flush || load_use) begin
      ex_valid_d     = 1'b0;
      ex_pc_d        = '0;
      ex_rs1_data_d  = '0;
      ex_rs2_data_d  = '0;
      ex_imm_d       = '0;
      ex_rs1_d       = '0;
      ex_rs2_d       = '0;
      ex_rd_d        = '0;
      ex_a_pc_d      = 1'b0;
      ex_b_imm_d     = 1'b0;
      ex_alu_sel_d   = ALU_ADD;
      ex_reg_write_d = 1'b0;
      ex_mem_read_d  = 1'b0;
      ex_mem_write_d = 1'b0;
    end
  end

  // Count inserted bubbles, sticking at all-ones rather than wrapping.
  always_comb begin
    bubble_cnt_d = bubble_cnt_q;
    if (stall_o && (bubble_cnt_q != '1)) begin
      bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
    end
  end

  // ID/EX register and bubble counter; reset empties the slot and drops any pending stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid_q     <= 1'b0;
      ex_pc_q        <= '0;
      ex_rs1_data_q  <= '0;
      ex_rs2_data_q  <= '0;
      ex_imm_q       <= '0;
      ex_rs1_q       <= '0;
      ex_rs2_q       <= '0;
      ex_rd_q        <= '0;
      ex_a_pc_q      <= 1'b0;
      ex_b_imm_q     <= 1'b0;
      ex_alu_sel_q   <= ALU_ADD;
      ex_reg_write_q <= 1'b0;
      ex_mem_read_q  <= 1'b0;
      ex_mem_write_q <= 1'b0;
      bubble_cnt_q   <= '0;
    end else begin
      ex_valid_q     <= ex_valid_d;
      ex_pc_q        <= ex_pc_d;
      ex_rs1_data_q  <= ex_rs1_data_d;
      ex_rs2_data_q  <= ex_rs2_data_d;
      ex_imm_q       <= ex_imm_d;
      ex_rs1_q       <= ex_rs1_d;
      ex_rs2_q       <= ex_rs2_d;
      ex_rd_q        <= ex_rd_d;
      ex_a_pc_q      <= ex_a_pc_d;
      ex_b_imm_q     <= ex_b_imm_d;
      ex_alu_sel_q   <= ex_alu_sel_d;
      ex_reg_write_q <= ex_reg_write_d;
      ex_mem_read_q  <= ex_mem_read_d;
      ex_mem_write_q <= ex_mem_write_d;
      bubble_cnt_q   <= bubble_cnt_d;
    end
  end

  fwd_select #(.N(N)) u_fwd_rs1 (
    .ex_rs         (ex_rs1_q),
    .reg_data      (ex_rs1_data_q),
    .mem_rd        (mem_rd),
    .mem_reg_write (mem_reg_write),
    .mem_result    (mem_result),
    .wb_rd         (wb_rd),
    .wb_reg_write  (wb_reg_write),
    .wb_result     (wb_result),
    .fwd_data      (fwd_rs1)
  );

  fwd_select #(.N(N)) u_fwd_rs2 (
    .ex_rs         (ex_rs2_q),
    .reg_data      (ex_rs2_data_q),
    .mem_rd        (mem_rd),
    .mem_reg_write (mem_reg_write),
    .mem_result    (mem_result),
    .wb_rd         (wb_rd),
    .wb_reg_write  (wb_reg_write),
    .wb_result     (wb_result),
    .fwd_data      (fwd_rs2)
  );

  assign alu_a         = ex_a_pc_q  ? ex_pc_q  : fwd_rs1;
  assign alu_b         = ex_b_imm_q ? ex_imm_q : fwd_rs2;
  assign ex_store_data = fwd_rs2;
  assign alu_sel_o     = ex_alu_sel_q;
  assign ex_valid      = ex_valid_q;
  assign ex_reg_write  = ex_reg_write_q;
  assign ex_mem_read   = ex_mem_read_q;
  assign ex_mem_write  = ex_mem_write_q;
  assign ex_rd         = ex_rd_q;
  assign bubble_cnt    = bubble_cnt_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Self-checking bench for alu_issue_stage: directed corners, forwarding table, random vs. model.
module tb_alu_issue_stage;
  import alu_issue_stage_pkg::*;

  localparam int N       = 32;
  localparam int CNT_W   = 3;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  typedef struct {
    logic [31:0] pc, rs1_data, rs2_data, imm;
    logic [4:0]  rs1, rs2, rd;
    logic        use_rs1, use_rs2, a_pc, b_imm;
    logic [3:0]  sel;
    logic        reg_write, mem_read, mem_write;
  } instr_t;

  typedef struct {
    instr_t      ins;
    logic [4:0]  mem_rd, wb_rd;
    logic        mem_rw, wb_rw;
    logic [31:0] mem_res, wb_res;
    logic [31:0] exp_a, exp_b, exp_store;
  } vec_t;

  logic             clk;
  logic             rst_n;
  logic             id_valid;
  logic [N-1:0]     id_pc, id_rs1_data, id_rs2_data, id_imm;
  logic [4:0]       id_rs1, id_rs2, id_rd;
  logic             id_use_rs1, id_use_rs2, id_a_pc, id_b_imm;
  logic [3:0]       id_alu_sel;
  logic             id_reg_write, id_mem_read, id_mem_write;
  logic             flush;
  logic [4:0]       mem_rd, wb_rd;
  logic             mem_reg_write, wb_reg_write;
  logic [N-1:0]     mem_result, wb_result;
  logic             stall_o;
  logic [N-1:0]     alu_a, alu_b;
  logic [3:0]       alu_sel_o;
  logic             ex_valid, ex_reg_write, ex_mem_read, ex_mem_write;
  logic [4:0]       ex_rd;
  logic [N-1:0]     ex_store_data;
  logic [CNT_W-1:0] bubble_cnt;

  int tests_run    = 0;
  int tests_failed = 0;

  alu_issue_stage #(.N(N), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_pc(id_pc),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_a_pc(id_a_pc), .id_b_imm(id_b_imm),
    .id_alu_sel(id_alu_sel), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
    .id_mem_write(id_mem_write), .flush(flush), .mem_rd(mem_rd), .wb_rd(wb_rd),
    .mem_reg_write(mem_reg_write), .wb_reg_write(wb_reg_write),
    .mem_result(mem_result), .wb_result(wb_result), .stall_o(stall_o),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel_o(alu_sel_o), .ex_valid(ex_valid),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_rd(ex_rd), .ex_store_data(ex_store_data), .bubble_cnt(bubble_cnt)
  );

  // Free-running clock, 10 time units per cycle.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard time limit so a broken design can never hang the run.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input instr_t i, input logic valid);
    id_valid     = valid;
    id_pc        = i.pc;
    id_rs1_data  = i.rs1_data;
    id_rs2_data  = i.rs2_data;
    id_imm       = i.imm;
    id_rs1       = i.rs1;
    id_rs2       = i.rs2;
    id_rd        = i.rd;
    id_use_rs1   = i.use_rs1;
    id_use_rs2   = i.use_rs2;
    id_a_pc      = i.a_pc;
    id_b_imm     = i.b_imm;
    id_alu_sel   = i.sel;
    id_reg_write = i.reg_write;
    id_mem_read  = i.mem_read;
    id_mem_write = i.mem_write;
  endtask

  task automatic setForward(input logic [4:0] mrd, input logic mrw, input logic [31:0] mres,
                            input logic [4:0] wrd, input logic wrw, input logic [31:0] wres);
    mem_rd = mrd; mem_reg_write = mrw; mem_result = mres;
    wb_rd  = wrd; wb_reg_write  = wrw; wb_result  = wres;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic instr_t nopInstr();
    instr_t i;
    i = '{pc: 0, rs1_data: 0, rs2_data: 0, imm: 0, rs1: 0, rs2: 0, rd: 0, use_rs1: 0,
          use_rs2: 0, a_pc: 0, b_imm: 0, sel: ALU_ADD, reg_write: 0, mem_read: 0, mem_write: 0};
    return i;
  endfunction

  // Reference forwarding rule: youngest non-x0 writer of the register wins.
  function automatic logic [31:0] fwdRef(input logic [4:0] rs, input logic [31:0] regval);
    if (mem_reg_write && mem_rd != 0 && mem_rd == rs) return mem_result;
    if (wb_reg_write && wb_rd != 0 && wb_rd == rs) return wb_result;
    return regval;
  endfunction

  vec_t   vecs[6];
  instr_t lw, add_dep, addi, cur, m_ex;
  int     m_kind;
  int     m_cnt;
  logic   cur_valid, held, exp_lu, exp_stall;

  initial begin
    // Forwarding table: instruction placed in EX, then forwarding sources applied.
    for (int k = 0; k < 6; k++) begin
      vecs[k].ins = nopInstr();
      vecs[k].ins.reg_write = 1'b1;
    end
    vecs[0].ins.rs1 = 3; vecs[0].ins.rs2 = 4; vecs[0].ins.rs1_data = 32'h100; vecs[0].ins.rs2_data = 32'h200;
    vecs[0].ins.sel = ALU_SUB; vecs[0].ins.rd = 10;
    vecs[0].mem_rd = 3; vecs[0].mem_rw = 1; vecs[0].mem_res = 32'h11;
    vecs[0].wb_rd = 3;  vecs[0].wb_rw = 1;  vecs[0].wb_res = 32'h22;
    vecs[0].exp_a = 32'h11; vecs[0].exp_b = 32'h200; vecs[0].exp_store = 32'h200;

    vecs[1].ins.rs1 = 1; vecs[1].ins.rs2 = 0; vecs[1].ins.rs1_data = 32'h5; vecs[1].ins.rs2_data = 32'h0;
    vecs[1].ins.sel = ALU_XOR; vecs[1].ins.rd = 11;
    vecs[1].mem_rd = 0; vecs[1].mem_rw = 1; vecs[1].mem_res = 32'hFF;
    vecs[1].wb_rd = 0;  vecs[1].wb_rw = 1;  vecs[1].wb_res = 32'hEE;
    vecs[1].exp_a = 32'h5; vecs[1].exp_b = 32'h0; vecs[1].exp_store = 32'h0;

    vecs[2].ins.rs1 = 2; vecs[2].ins.rs2 = 9; vecs[2].ins.rs1_data = 32'h40; vecs[2].ins.rs2_data = 32'h1234;
    vecs[2].ins.b_imm = 1; vecs[2].ins.imm = 32'h8; vecs[2].ins.reg_write = 0; vecs[2].ins.mem_write = 1;
    vecs[2].mem_rd = 5; vecs[2].mem_rw = 1; vecs[2].mem_res = 32'h99;
    vecs[2].wb_rd = 9;  vecs[2].wb_rw = 1;  vecs[2].wb_res = 32'hABCD;
    vecs[2].exp_a = 32'h40; vecs[2].exp_b = 32'h8; vecs[2].exp_store = 32'hABCD;

    vecs[3].ins.rs1 = 7; vecs[3].ins.rs2 = 7; vecs[3].ins.rs1_data = 32'h1; vecs[3].ins.rs2_data = 32'h2;
    vecs[3].ins.sel = ALU_OR; vecs[3].ins.rd = 12;
    vecs[3].mem_rd = 7; vecs[3].mem_rw = 0; vecs[3].mem_res = 32'h99;
    vecs[3].wb_rd = 7;  vecs[3].wb_rw = 1;  vecs[3].wb_res = 32'h77;
    vecs[3].exp_a = 32'h77; vecs[3].exp_b = 32'h77; vecs[3].exp_store = 32'h77;

    vecs[4].ins.pc = 32'h1000; vecs[4].ins.a_pc = 1; vecs[4].ins.rs1 = 4; vecs[4].ins.rs1_data = 32'h3;
    vecs[4].ins.rs2 = 5; vecs[4].ins.rs2_data = 32'h33; vecs[4].ins.sel = ALU_SLTU; vecs[4].ins.rd = 13;
    vecs[4].mem_rd = 4; vecs[4].mem_rw = 1; vecs[4].mem_res = 32'h55;
    vecs[4].wb_rd = 1;  vecs[4].wb_rw = 1;  vecs[4].wb_res = 32'h66;
    vecs[4].exp_a = 32'h1000; vecs[4].exp_b = 32'h33; vecs[4].exp_store = 32'h33;

    vecs[5].ins.rs1 = 6; vecs[5].ins.rs2 = 6; vecs[5].ins.rs1_data = 32'h10; vecs[5].ins.rs2_data = 32'h10;
    vecs[5].ins.sel = ALU_SRA; vecs[5].ins.rd = 14;
    vecs[5].mem_rd = 6; vecs[5].mem_rw = 1; vecs[5].mem_res = 32'hCAFE;
    vecs[5].wb_rd = 6;  vecs[5].wb_rw = 1;  vecs[5].wb_res = 32'hBEEF;
    vecs[5].exp_a = 32'hCAFE; vecs[5].exp_b = 32'hCAFE; vecs[5].exp_store = 32'hCAFE;

    lw = nopInstr();
    lw.rd = 5; lw.rs1 = 1; lw.use_rs1 = 1; lw.b_imm = 1; lw.imm = 4; lw.reg_write = 1; lw.mem_read = 1;
    add_dep = nopInstr();
    add_dep.rs1 = 5; add_dep.rs2 = 7; add_dep.rd = 6; add_dep.use_rs1 = 1; add_dep.use_rs2 = 1;
    add_dep.reg_write = 1;
    addi = nopInstr();
    addi.pc = 32'h40; addi.rd = 1; addi.b_imm = 1; addi.imm = 32'h2A; addi.use_rs1 = 1; addi.reg_write = 1;

    // Reset state.
    rst_n = 1'b0;
    flush = 1'b0;
    applyStimulus(nopInstr(), 1'b0);
    setForward(0, 0, 0, 0, 0, 0);
    nextCycle();
    nextCycle();
    checkOutput("reset_ex_valid", ex_valid, 0);
    checkOutput("reset_stall", stall_o, 0);
    checkOutput("reset_alu_sel", alu_sel_o, ALU_ADD);
    checkOutput("reset_bubble_cnt", bubble_cnt, 0);
    checkOutput("reset_ctrl", {ex_reg_write, ex_mem_read, ex_mem_write}, 0);
    rst_n = 1'b1;
    nextCycle();

    // Load-use: one stall cycle, one bubble, then the dependent instruction issues.
    applyStimulus(lw, 1'b1);
    nextCycle();
    applyStimulus(add_dep, 1'b1);
    #2;
    checkOutput("lu_stall", stall_o, 1);
    checkOutput("lu_cnt_before", bubble_cnt, 0);
    checkOutput("lu_load_in_ex", {ex_valid, ex_mem_read}, 2'b11);
    nextCycle();
    #2;
    checkOutput("lu_bubble_valid", ex_valid, 0);
    checkOutput("lu_bubble_ctrl", {ex_reg_write, ex_mem_read, ex_mem_write}, 0);
    checkOutput("lu_bubble_sel", alu_sel_o, ALU_ADD);
    checkOutput("lu_stall_clears", stall_o, 0);
    checkOutput("lu_cnt_after", bubble_cnt, 1);
    nextCycle();
    applyStimulus(nopInstr(), 1'b0);
    #2;
    checkOutput("lu_dep_issued", {ex_valid, ex_reg_write, ex_rd}, {1'b1, 1'b1, 5'd6});
    nextCycle();

    // Flush overrides load-use: no stall, empty slot, counter untouched.
    applyStimulus(lw, 1'b1);
    nextCycle();
    applyStimulus(add_dep, 1'b1);
    flush = 1'b1;
    #2;
    checkOutput("flush_stall", stall_o, 0);
    nextCycle();
    flush = 1'b0;
    applyStimulus(nopInstr(), 1'b0);
    #2;
    checkOutput("flush_ex_valid", ex_valid, 0);
    checkOutput("flush_cnt", bubble_cnt, 1);
    nextCycle();

    // Reset in the middle of a stall.
    applyStimulus(lw, 1'b1);
    nextCycle();
    applyStimulus(add_dep, 1'b1);
    #2;
    checkOutput("rst_pre_stall", stall_o, 1);
    rst_n = 1'b0;
    #1;
    checkOutput("rst_mid_stall", stall_o, 0);
    checkOutput("rst_mid_valid", ex_valid, 0);
    checkOutput("rst_mid_cnt", bubble_cnt, 0);
    checkOutput("rst_mid_sel", alu_sel_o, ALU_ADD);
    checkOutput("rst_mid_ops", {alu_a, alu_b, ex_store_data}, 0);
    checkOutput("rst_mid_ctrl", {ex_reg_write, ex_mem_read, ex_mem_write, ex_rd}, 0);
    nextCycle();
    rst_n = 1'b1;
    applyStimulus(addi, 1'b1);
    nextCycle();
    applyStimulus(nopInstr(), 1'b0);
    #2;
    checkOutput("rst_after_issue", {ex_valid, ex_reg_write, ex_rd}, {1'b1, 1'b1, 5'd1});
    checkOutput("rst_after_alu_b", alu_b, 32'h2A);
    nextCycle();

    // Repeated load-use pairs: one bubble each, counter saturates.
    for (int k = 1; k <= CNT_MAX + 2; k++) begin
      applyStimulus(lw, 1'b1);
      nextCycle();
      applyStimulus(add_dep, 1'b1);
      #2;
      checkOutput("sat_stall", stall_o, 1);
      nextCycle();
      #2;
      checkOutput("sat_self_clear", stall_o, 0);
      checkOutput("sat_cnt", bubble_cnt, (k > CNT_MAX) ? CNT_MAX : k);
      nextCycle();
    end

    // Forwarding table.
    for (int k = 0; k < 6; k++) begin
      applyStimulus(vecs[k].ins, 1'b1);
      setForward(0, 0, 0, 0, 0, 0);
      nextCycle();
      applyStimulus(nopInstr(), 1'b0);
      setForward(vecs[k].mem_rd, vecs[k].mem_rw, vecs[k].mem_res,
                 vecs[k].wb_rd, vecs[k].wb_rw, vecs[k].wb_res);
      #2;
      checkOutput($sformatf("tbl%0d_alu_a", k), alu_a, vecs[k].exp_a);
      checkOutput($sformatf("tbl%0d_alu_b", k), alu_b, vecs[k].exp_b);
      checkOutput($sformatf("tbl%0d_store", k), ex_store_data, vecs[k].exp_store);
      checkOutput($sformatf("tbl%0d_sel", k), alu_sel_o, vecs[k].ins.sel);
      nextCycle();
    end
    setForward(0, 0, 0, 0, 0, 0);

    // Random traffic against a slot-level reference model.
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    m_kind = 0;
    m_cnt  = 0;
    m_ex   = nopInstr();
    held   = 1'b0;
    cur    = nopInstr();
    cur_valid = 1'b0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if (!held) begin
        cur.pc        = $urandom;
        cur.rs1_data  = $urandom;
        cur.rs2_data  = $urandom;
        cur.imm       = $urandom;
        cur.rs1       = 5'($urandom_range(0, 3));
        cur.rs2       = 5'($urandom_range(0, 3));
        cur.rd        = 5'($urandom_range(0, 3));
        cur.use_rs1   = 1'($urandom_range(0, 1));
        cur.use_rs2   = 1'($urandom_range(0, 1));
        cur.a_pc      = 1'($urandom_range(0, 1));
        cur.b_imm     = 1'($urandom_range(0, 1));
        cur.sel       = 4'($urandom_range(0, 9));
        cur.reg_write = 1'($urandom_range(0, 1));
        cur.mem_read  = ($urandom_range(0, 2) == 0);
        cur.mem_write = 1'($urandom_range(0, 1));
        cur_valid     = ($urandom_range(0, 3) != 0);
      end
      applyStimulus(cur, cur_valid);
      flush = ($urandom_range(0, 7) == 0);
      setForward(5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), $urandom,
                 5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), $urandom);
      #2;
      exp_lu = (m_kind == 1) && m_ex.mem_read && (m_ex.rd != 0) && cur_valid &&
               ((cur.use_rs1 && cur.rs1 == m_ex.rd) || (cur.use_rs2 && cur.rs2 == m_ex.rd));
      exp_stall = exp_lu && !flush;
      checkOutput("rnd_ex_valid", ex_valid, (m_kind == 1));
      checkOutput("rnd_stall", stall_o, exp_stall);
      checkOutput("rnd_bubble_cnt", bubble_cnt, m_cnt);
      if (m_kind == 0) begin
        checkOutput("rnd_empty_ctrl", {ex_reg_write, ex_mem_read, ex_mem_write}, 0);
        checkOutput("rnd_empty_sel", alu_sel_o, ALU_ADD);
      end else if (m_kind == 1) begin
        checkOutput("rnd_ctrl", {ex_reg_write, ex_mem_read, ex_mem_write},
                    {m_ex.reg_write, m_ex.mem_read, m_ex.mem_write});
        checkOutput("rnd_sel", alu_sel_o, m_ex.sel);
        checkOutput("rnd_rd", ex_rd, m_ex.rd);
        checkOutput("rnd_alu_a", alu_a, m_ex.a_pc ? m_ex.pc : fwdRef(m_ex.rs1, m_ex.rs1_data));
        checkOutput("rnd_alu_b", alu_b, m_ex.b_imm ? m_ex.imm : fwdRef(m_ex.rs2, m_ex.rs2_data));
        checkOutput("rnd_store", ex_store_data, fwdRef(m_ex.rs2, m_ex.rs2_data));
      end
      if (exp_stall && m_cnt < CNT_MAX) m_cnt++;
      if (flush || exp_lu) begin
        m_kind = 0;
      end else begin
        m_ex   = cur;
        m_kind = cur_valid ? 1 : 2;
      end
      held = exp_stall;
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
